mem_port_arbiter: RTL

- Sits between the unified word-addressed RAM and two requesters: instruction fetch (port 0) and load/store datapath (port 1).
- Arbitrates between the two requesters with round-robin priority.
- Sequences the RAM's read/write/enable strobe as a multi-cycle transaction.
- Returns read data to each requester through a req/done handshake.
- Guarantees the RAM sees stable addr/data/read/write before the enable rising edge.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the RAM-side bus of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_SPACE = 9
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_SPACE-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_done;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_SPACE-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_done;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [ADDR_SPACE-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_datain;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_enable;
  logic [DATA_WIDTH-1:0] mem_dataout;

  logic                  busy;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_dataout,
    output p0_gnt, p0_done, p0_rdata,
    output p1_gnt, p1_done, p1_rdata,
    output mem_addr, mem_datain, mem_read, mem_write, mem_enable,
    output busy
  );

  // Requester / RAM side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_dataout,
    input  p0_gnt, p0_done, p0_rdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  mem_addr, mem_datain, mem_read, mem_write, mem_enable,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single word-addressed RAM.
// Each access runs IDLE -> SETUP -> STROBE -> HOLD -> DONE so that the RAM
// sees stable addr/data/read/write before and after its enable rising edge.
// Every output comes straight from a register.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_SPACE = 9
) (
  input logic               clk,
  input logic               clr,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;     // 0 = port 0 granted last, 1 = port 1
  logic                  owner_q, owner_d;
  logic [ADDR_SPACE-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdin_q, mdin_d;
  logic                  mrd_q, mrd_d;
  logic                  mwr_q, mwr_d;
  logic                  men_q, men_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  busy_q, busy_d;
  logic                  pick;
  logic                  pick_we;

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they can be registered without adding latency.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    men_d   = men_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = done0_q;
    done1_d = done1_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    busy_d  = busy_q;
    pick    = 1'b0;
    pick_we = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.p0_req && bus.p1_req) pick = ~last_q;
        else                          pick = bus.p1_req;
        pick_we = pick ? bus.p1_we : bus.p0_we;
        if (bus.p0_req || bus.p1_req) begin
          state_d = S_SETUP;
          owner_d = pick;
          last_d  = pick;
          maddr_d = pick ? bus.p1_addr  : bus.p0_addr;
          mdin_d  = pick ? bus.p1_wdata : bus.p0_wdata;
          mwr_d   = pick_we;
          mrd_d   = ~pick_we;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        men_d   = 1'b1;
      end
      S_STROBE: begin
        state_d = S_HOLD;
        men_d   = 1'b0;
      end
      S_HOLD: begin
        state_d = S_DONE;
        if (mrd_q) begin
          if (owner_q) rd1_d = bus.mem_dataout;
          else         rd0_d = bus.mem_dataout;
        end
        done0_d = ~owner_q;
        done1_d = owner_q;
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        done0_d = 1'b0;
        done1_d = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        men_d   = 1'b0;
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves port 1 as last grant so port 0 wins first tie.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      men_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      men_q   <= men_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.p0_gnt     = gnt0_q;
  assign bus.p0_done    = done0_q;
  assign bus.p0_rdata   = rd0_q;
  assign bus.p1_gnt     = gnt1_q;
  assign bus.p1_done    = done1_q;
  assign bus.p1_rdata   = rd1_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_datain = mdin_q;
  assign bus.mem_read   = mrd_q;
  assign bus.mem_write  = mwr_q;
  assign bus.mem_enable = men_q;
  assign bus.busy       = busy_q;

endmodule
